// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_unit_perf_cnt.sv
// Fetch and redirect event counters; wrap at 2^32, cleared by rst.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        redirect_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q + {31'd0, fetch_inc};
    redirect_cnt_d = redirect_cnt_q + {31'd0, redirect_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, single outstanding imem request, redirect on br_taken.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= F_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      F_REQ: begin
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = F_WAIT;
          // A redirect racing the handshake makes the accepted request stale.
          drop_d   = br_taken;
        end
      end
      F_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = F_REQ;
          if (!drop_q && !br_taken) begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = req_pc_q;
            pc_d       = req_pc_q + PC_INC;
            state_d    = F_HOLD;
          end
        end else if (br_taken) begin
          drop_d = 1'b1;
        end
      end
      F_HOLD: begin
        if (if_ready || br_taken) begin
          state_d = F_REQ;
        end
      end
      default: state_d = F_REQ;
    endcase
    if (br_taken) begin
      pc_d = word_align(br_target);
    end
  end

  always_comb begin
    imem_req_valid = (state_q == F_REQ) && !rst;
    imem_addr      = pc_q;
    if_valid       = (state_q == F_HOLD) && !rst;
    if_instr       = if_instr_q;
    if_pc          = if_pc_q;
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .fetch_inc    (if_valid && if_ready),
    .redirect_inc (br_taken),
    .fetch_cnt    (perf_fetch_cnt),
    .redirect_cnt (perf_redirect_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model and memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one optional outstanding request plus one buffered instruction.
  logic [31:0] m_pc, m_out_addr, m_buf_instr, m_buf_pc, m_perf_f, m_perf_r;
  bit          m_out, m_out_stale, m_buf;

  // Memory responder
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          mem_lat = 1;

  logic [31:0] consumed_pc[$];
  logic [31:0] consumed_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] last_pc();
    if (consumed_pc.size() == 0) return 32'hFFFF_FFFF;
    return consumed_pc[consumed_pc.size()-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_out_stale = 0; m_out_addr = 32'h0;
    m_buf = 0; m_buf_instr = 32'h0000_0013; m_buf_pc = 32'h0;
    m_perf_f = 0; m_perf_r = 0;
  endtask

  task automatic model_update();
    bit req_e;
    bit b0;
    req_e = !m_out && !m_buf;
    b0    = m_buf;
    if (rst) begin
      model_reset();
    end else begin
      if (b0 && if_ready) m_perf_f++;
      if (br_taken) m_perf_r++;
      if (m_out && imem_rsp_valid) begin
        m_out = 0;
        if (!m_out_stale && !br_taken) begin
          m_buf = 1; m_buf_instr = imem_rsp_data; m_buf_pc = m_out_addr;
          m_pc = m_out_addr + 32'd4;
        end
      end else if (m_out && br_taken) begin
        m_out_stale = 1;
      end
      if (req_e && imem_req_ready) begin
        m_out = 1; m_out_addr = m_pc; m_out_stale = br_taken;
      end
      if (b0 && (if_ready || br_taken)) m_buf = 0;
      if (br_taken) m_pc = br_target & ~32'd3;
    end
  endtask

  // One clock cycle: drive memory, compare outputs against the model, advance.
  task automatic tick();
    bit          hs;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pend = 0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    chk("imem_req_valid", {31'd0, imem_req_valid}, {31'd0, !rst && !m_out && !m_buf});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, !rst && m_buf});
    chk("if_instr", if_instr, m_buf_instr);
    chk("if_pc", if_pc, m_buf_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_perf_f);
    chk("perf_redirect_cnt", perf_redirect_cnt, m_perf_r);
`endif
    hs = imem_req_valid && imem_req_ready;
    a  = imem_addr;
    if (if_valid && if_ready) begin
      consumed_pc.push_back(if_pc);
      consumed_instr.push_back(if_instr);
      $display("fetch: pc=%08h instr=%08h t=%0t", if_pc, if_instr, $time);
    end
    @(posedge clk);
    model_update();
    if (hs) begin
      mem_pend = 1; mem_addr = a; mem_wait = mem_lat - 1;
    end
    @(negedge clk);
  endtask

  // which: 0 = request outstanding, 1 = instruction held, 2 = ready to request
  task automatic wait_for(input int which, input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if ((which == 0 && m_out) || (which == 1 && m_buf) || (which == 2 && !m_out && !m_buf)) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_%s: got timeout, required condition within 20 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; br_taken = 0; br_target = 0; imem_req_ready = 1; if_ready = 1;
    imem_rsp_valid = 0; imem_rsp_data = 0;
    mem_pend = 0; mem_addr = 0; mem_wait = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset cycle values
    tick();
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 32'h0);
    rst = 0;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Streaming: one instruction per 3 cycles
    repeat (9) tick();
    chk("stream_count", consumed_pc.size(), 32'd3);
    chk("stream_pc0", consumed_pc[0], 32'h0);
    chk("stream_pc1", consumed_pc[1], 32'h4);
    chk("stream_pc2", consumed_pc[2], 32'h8);
    chk("stream_instr1", consumed_instr[1], 32'h5A00_0413);

    // Decode stall in hold
    if_ready = 0;
    wait_for(1, "hold");
    repeat (5) tick();
    #1;
    chk("stall_if_pc", if_pc, 32'hC);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    if_ready = 1;
    tick();
    #1;
    chk("release_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("release_addr", imem_addr, 32'h10);

    // Redirect while waiting on a slow response
    mem_lat = 3;
    tick();
    br_taken = 1; br_target = 32'h0000_0103;
    tick();
    br_taken = 0;
    tick();
    tick();
    #1;
    chk("late_drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("late_drop_addr", imem_addr, 32'h100);
    chk("late_drop_if_valid", {31'd0, if_valid}, 32'd0);
    mem_lat = 1;
    repeat (3) tick();
    chk("late_drop_fetch", last_pc(), 32'h100);

    // Redirect coinciding with the response
    wait_for(0, "wait");
    br_taken = 1; br_target = 32'h0000_0040;
    tick();
    br_taken = 0;
    #1;
    chk("same_cycle_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("same_cycle_addr", imem_addr, 32'h40);
    chk("same_cycle_if_valid", {31'd0, if_valid}, 32'd0);
    repeat (3) tick();
    chk("same_cycle_fetch", last_pc(), 32'h40);

    // Memory back-pressure then redirect of an unaccepted request
    wait_for(2, "req");
    imem_req_ready = 0;
    repeat (4) tick();
    br_taken = 1; br_target = 32'h0000_0200;
    tick();
    br_taken = 0;
    #1;
    chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("bp_addr", imem_addr, 32'h200);
    imem_req_ready = 1;
    repeat (3) tick();
    chk("bp_fetch", last_pc(), 32'h200);

    // Redirect while holding an instruction
    if_ready = 0;
    wait_for(1, "hold2");
    br_taken = 1; br_target = 32'h0000_0300;
    tick();
    br_taken = 0;
    #1;
    chk("hold_br_if_valid", {31'd0, if_valid}, 32'd0);
    chk("hold_br_addr", imem_addr, 32'h300);
    if_ready = 1;
    repeat (3) tick();
    chk("hold_br_fetch", last_pc(), 32'h300);

    // Reset while a request is outstanding; its response arrives afterwards
    mem_lat = 2;
    wait_for(0, "wait2");
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_wait_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_wait_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_redirect", perf_redirect_cnt, 32'd0);
`endif
    repeat (6) tick();
    chk("rst_wait_fetch", last_pc(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
